// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// STG_* names give instantiating code readable redir_stage values.
package pipe_ctrl_pkg;

   localparam int NSTAGE_DEF   = 8;
   localparam int MAX_INFL_DEF = 2;
   localparam int SW_DEF       = $clog2(NSTAGE_DEF);

   typedef logic [SW_DEF-1:0] stage_idx_t;

   localparam stage_idx_t STG_PC = stage_idx_t'(0);
   localparam stage_idx_t STG_F  = stage_idx_t'(1);
   localparam stage_idx_t STG_D  = stage_idx_t'(2);
   localparam stage_idx_t STG_E  = stage_idx_t'(3);
   localparam stage_idx_t STG_M  = stage_idx_t'(5);
   localparam stage_idx_t STG_W  = stage_idx_t'(7);

endpackage

// File: rtl/pipe_ctrl_fetch_drop_tracker.sv
// Counts outstanding fetch requests and how many of them are wrong-path,
// so stale responses can be discarded without ever holding the PC stage.
module fetch_drop_tracker
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_INFL = MAX_INFL_DEF,
   parameter int CW       = $clog2(MAX_INFL + 1)
) (
   input  logic clk,
   input  logic resetn,
   input  logic redir_accept_i,
   input  logic req_fire_i,
   input  logic resp_valid_i,
   output logic resp_drop_o,
   output logic can_req_o
);

   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;

   // A redirect marks everything still outstanding, including a request
   // fired in the same cycle, as wrong-path.
   always_comb begin
      inflight_d = inflight_q + CW'(req_fire_i) - CW'(resp_valid_i);
      if (redir_accept_i) begin
         drop_d = inflight_d;
      end else begin
         drop_d = drop_q - CW'(resp_valid_i && (drop_q != '0));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // The redirect itself flushes stage 1, so its own response is left alone.
   assign resp_drop_o = resetn && resp_valid_i && (drop_q != '0) && !redir_accept_i;
   assign can_req_o   = resetn && (inflight_q < CW'(MAX_INFL));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: arbitrates wait requests and redirect
// sources into per-stage stall/flush vectors and tracks wrong-path fetches.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE   = NSTAGE_DEF,
   parameter int NRED     = 3,
   parameter int MAX_INFL = MAX_INFL_DEF,
   parameter int SW       = $clog2(NSTAGE),
   parameter int CW       = $clog2(MAX_INFL + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NSTAGE-1:0]    wait_req,
   input  logic [NRED-1:0]      redir_valid,
   input  logic [NRED*SW-1:0]   redir_stage,
   input  logic [NRED-1:0]      redir_self,
   output logic [NRED-1:0]      redir_ack,
   input  logic                 if_req_fire,
   input  logic                 if_resp_valid,
   output logic                 if_resp_drop,
   output logic                 if_can_req,
   output logic [NSTAGE-1:0]    stall,
   output logic [NSTAGE-1:0]    flush
);

   logic              red_any;
   logic [SW-1:0]     red_stage;
   logic [NRED-1:0]   red_onehot;
   logic              red_self;
   logic              w_any;
   logic [SW-1:0]     w_stage;
   logic              red_accept;
   logic [NSTAGE-1:0] flush_red;
   logic [NSTAGE-1:0] flush_wait;
   logic [NSTAGE-1:0] stall_wait;

   // Strictly-greater compare keeps the lowest source index on equal stages.
   always_comb begin
      red_any    = 1'b0;
      red_stage  = '0;
      red_onehot = '0;
      red_self   = 1'b0;
      for (int i = 0; i < NRED; i++) begin
         if (redir_valid[i] && (!red_any || (redir_stage[i*SW +: SW] > red_stage))) begin
            red_any       = 1'b1;
            red_stage     = redir_stage[i*SW +: SW];
            red_onehot    = '0;
            red_onehot[i] = 1'b1;
            red_self      = redir_self[i];
         end
      end
   end

   always_comb begin
      w_any   = 1'b0;
      w_stage = '0;
      for (int s = 0; s < NSTAGE; s++) begin
         if (wait_req[s]) begin
            w_any   = 1'b1;
            w_stage = SW'(s);
         end
      end
   end

   for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_pc
         assign flush_red[gi]  = (red_stage == '0) && red_self;
         assign flush_wait[gi] = 1'b0;
      end else begin : g_body
         assign flush_red[gi]  = (gi < int'(red_stage)) || ((gi == int'(red_stage)) && red_self);
         assign flush_wait[gi] = (gi == int'(w_stage) + 1);
      end
      assign stall_wait[gi] = (gi <= int'(w_stage));
   end

   // A redirect wins ties with a wait at the same stage.
   always_comb begin
      stall      = '0;
      flush      = '0;
      redir_ack  = '0;
      red_accept = 1'b0;
      if (!resetn) begin
         flush = '1;
      end else if (red_any && (!w_any || (w_stage <= red_stage))) begin
         flush      = flush_red;
         redir_ack  = red_onehot;
         red_accept = 1'b1;
      end else if (w_any) begin
         stall = stall_wait;
         flush = flush_wait;
      end
   end

   fetch_drop_tracker #(
      .MAX_INFL (MAX_INFL),
      .CW       (CW)
   ) u_fetch_drop_tracker (
      .clk            (clk),
      .resetn         (resetn),
      .redir_accept_i (red_accept),
      .req_fire_i     (if_req_fire),
      .resp_valid_i   (if_resp_valid),
      .resp_drop_o    (if_resp_drop),
      .can_req_o      (if_can_req)
   );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline stall/flush controller for the in-order core. It arbitrates per-stage wait requests and multiple redirect sources (branch, exception, refetch) into per-stage stall and flush vectors. It also tracks in-flight instruction-fetch requests, so wrong-path fetch responses are discarded by counting rather than by freezing fetch until the I-cache goes idle. It sits beside the pipeline registers and drives every stage's enable/clear.

## Interface
- NSTAGE, 8: pipeline register stages; stage 0 is the PC/fetch-request stage.
- NRED, 3: redirect sources.
- MAX_INFL, 2: max outstanding fetch requests.
- SW, $clog2(NSTAGE): stage index width (derived).
- CW, $clog2(MAX_INFL+1): counter width (derived).
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- wait_req  in  NSTAGE  stage s cannot advance this cycle (D-cache miss, multicycle unit, queue full)
- redir_valid  in  NRED  redirect request from source i
- redir_stage  in  NRED*SW  stage index of source i
- redir_self  in  NRED  source i's own stage is also flushed (exception at commit)
- redir_ack  out  NRED  one-hot, winning redirect accepted this cycle
- if_req_fire  in  1  fetch request handshake completed
- if_resp_valid  in  1  fetch response returned
- if_resp_drop  out  1  current response is wrong-path, discard
- if_can_req  out  1  inflight < MAX_INFL
- stall  out  NSTAGE  hold stage register
- flush  out  NSTAGE  load bubble into stage register

## Operation
- Redirect arbitration: the deepest redir_stage among valid sources wins. On equal stages, the lowest source index wins. Losers are not acked and must hold their request.
- Wait arbitration: the deepest asserted wait_req bit, w, is the wait winner.
- Winning redirect at r, with no wait at w > r (a redirect wins ties with a wait):
  - flush[1..r-1] = 1.
  - flush[r] = redir_self.
  - stall = 0.
  - Stages > r advance normally.
- Wait winner w, with no redirect at r >= w:
  - stall[0..w] = 1.
  - flush[w+1] = 1 if w+1 < NSTAGE.
  - No ack.
- Neither condition: all stall and flush bits are 0.
- Fetch tracking uses two registered counters, inflight and drop. Each cycle:
  - inflight' = inflight + if_req_fire − if_resp_valid.
  - On an accepted redirect: drop' = inflight + if_req_fire − if_resp_valid. A request fired in the redirect cycle counts as wrong-path.
  - Otherwise: drop' = drop − (if_resp_valid && drop ≠ 0).
- Fetch outputs:
  - if_resp_drop = if_resp_valid && drop ≠ 0, combinational.
  - A response in the redirect cycle itself is not flagged dropped; stage 1 is flushed by the redirect anyway.
- Stage 0 is never stalled by an outstanding fetch. Stale responses are removed by drop, so the PC update is never delayed.
- Illegal input conditions (bench assertions; RTL behaviour unspecified):
  - if_resp_valid while inflight = 0.
  - if_req_fire while if_can_req = 0.
  - redir_stage ≥ NSTAGE.

## Timing
- All stall, flush, ack and if_resp_drop outputs are combinational from the current inputs and counters, with zero-cycle latency.
- Counters update on clk; a redirect's effect on if_resp_drop begins the next cycle.
- While resetn is low:
  - inflight = drop = 0.
  - flush = all 1, stall = 0, redir_ack = 0, if_resp_drop = 0, if_can_req = 0.
- Reset assertion mid-operation clears both counters immediately, discarding any outstanding fetch bookkeeping.
- Back-to-back redirects: a second redirect while drop ≠ 0 reloads drop from inflight; no accumulation is needed.
- Counter limits:
  - drop ≤ inflight ≤ MAX_INFL at all times.
  - Counters never wrap; underflow is only possible through an illegal input.

## Structure
- The shared package carries:
  - the stage-index typedef;
  - MAX_INFL default;
  - named stage constants (e.g. STG_F, STG_D, STG_E, STG_M, STG_W) used by instantiating code for redir_stage.
- Sub-module fetch_drop_tracker holds the inflight and drop counters plus if_resp_drop and if_can_req.
- The arbitration logic stays flat in pipe_ctrl.

## Test plan
- Single wait: NSTAGE=8, wait_req=0b0001_0000 (w=4) → stall=0b0001_1111, flush=0b0010_0000, no ack.
- Redirect vs wait:
  - redirect at stage 4 plus wait at stage 6 → stall[0..6]=1, flush[7]=1, ack=0.
  - Redirect moved to stage 6 (tie) → ack=1, flush[1..5]=1, flush[6]=redir_self.
- Source priority: sources 0 and 2 both valid at stage 5, plus source 1 valid at stage 3 → redir_ack=0b001. Repeat with source 2 at stage 6 → redir_ack=0b100.
- Drop counting:
  - Fire two requests (inflight=2), then redirect → drop=2 next cycle.
  - Next two responses have if_resp_drop=1; the third has 0.
  - if_can_req stays 0 while inflight=2.
- Redirect-cycle fetch activity:
  - With inflight=1, redirect together with if_req_fire=1 and if_resp_valid=1 → drop=1.
  - The following response is dropped.
- Async reset: deassert resetn mid-drop (drop=1) → counters clear without a clock edge, flush=all 1 while low. After release, a response is not dropped.
